// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quad_decoder
// Description : Quadrature encoder decoder with two-flop input synchronizers,
//               a stability filter, an 8-bit up/down position counter with
//               synchronous load, direction, step/wrap pulses and a sticky
//               illegal-transition flag.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_decoder #(
   // Consecutive stable samples needed to accept an input change (1..15)
   parameter int FILT_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       qa,
   input  logic       qb,
   input  logic       load,
   input  logic [7:0] data,
   input  logic       clr_err,
   output logic [7:0] count,
   output logic       dir,
   output logic       step,
   output logic       wrap,
   output logic       err
);

   localparam logic [4:0] FILT_W = 5'(FILT_LEN);

   logic       a_meta;
   logic       a_sync;
   logic       b_meta;
   logic       b_sync;
   logic [1:0] s_cur;
   logic [1:0] s_prev;
   logic [1:0] f_state;
   logic [3:0] win_cnt;
   logic [4:0] hits;
   logic       commit;
   logic       fwd;
   logic       rev;
   logic       illegal;

   assign s_cur = {a_sync, b_sync};

   // Two-flop synchronizers; left out of reset so sampling continues while rst is low
   always_ff @(posedge clk) begin
      a_meta <= qa;
      a_sync <= a_meta;
      b_meta <= qb;
      b_sync <= b_meta;
   end

   // Window length including this edge, commit decision and transition decode
   always_comb begin
      hits    = (s_cur == s_prev) ? ({1'b0, win_cnt} + 5'd1) : 5'd1;
      commit  = (s_cur != f_state) && (hits >= FILT_W);
      fwd     = 1'b0;
      rev     = 1'b0;
      case ({f_state, s_cur})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
         4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
         default: ;
      endcase
      illegal = ((f_state ^ s_cur) == 2'b11);
   end

   // Stability filter: F tracks S during reset so a static input never steps on release
   always_ff @(posedge clk) begin
      s_prev <= s_cur;
      if (!rst) begin
         f_state <= s_cur;
         win_cnt <= 4'd0;
      end else if (s_cur == f_state) begin
         win_cnt <= 4'd0;
      end else if (commit) begin
         win_cnt <= 4'd0;
         f_state <= s_cur;
      end else begin
         win_cnt <= hits[3:0];
      end
   end

   // Position counter, direction, pulses and sticky error; load discards a coincident step
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= 8'h00;
         dir   <= 1'b1;
         step  <= 1'b0;
         wrap  <= 1'b0;
         err   <= 1'b0;
      end else begin
         step <= 1'b0;
         wrap <= 1'b0;
         if (load) begin
            count <= data;
         end else if (commit && fwd) begin
            count <= count + 8'd1;
            dir   <= 1'b1;
            step  <= 1'b1;
            wrap  <= (count == 8'hFF);
         end else if (commit && rev) begin
            count <= count - 8'd1;
            dir   <= 1'b0;
            step  <= 1'b1;
            wrap  <= (count == 8'h00);
         end
         if (commit && illegal) begin
            err <= 1'b1;
         end else if (clr_err) begin
            err <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_decoder
// Description : Directed vector bench for quad_decoder (FILT_LEN = 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       qa = 1'b1;
   logic       qb = 1'b1;
   logic       load = 1'b0;
   logic [7:0] data = 8'h00;
   logic       clr_err = 1'b0;
   logic [7:0] count;
   logic       dir;
   logic       step;
   logic       wrap;
   logic       err;

   int tests = 0;
   int fails = 0;

   quad_decoder #(.FILT_LEN(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .qa      (qa),
      .qb      (qb),
      .load    (load),
      .data    (data),
      .clr_err (clr_err),
      .count   (count),
      .dir     (dir),
      .step    (step),
      .wrap    (wrap),
      .err     (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       a;
      logic       b;
      logic       clr;
      int         hold;
      logic [7:0] cnt;
      logic       dir;
      logic       err;
      int         steps;
      int         wraps;
      int         lat;     // tick on which the first step is seen, 0 = not checked
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs n edges, counting step/wrap pulses and noting the tick of the first step
   task automatic run(input int n, output int st, output int wr, output int first);
      st = 0;
      wr = 0;
      first = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (step === 1'b1) begin
            st++;
            if (first == 0) first = i + 1;
         end
         if (wrap === 1'b1) wr++;
      end
   endtask

   initial begin
      int st, wr, first;

      // Inputs change just after an edge; the next edge is the sampling edge, so the
      // commit edge (sampling edge + 4) is the 5th tick after the change.
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 10, 8'h01, 1'b1, 1'b0, 1, 0, 5};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 10, 8'h02, 1'b1, 1'b0, 1, 0, 5};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 10, 8'h03, 1'b1, 1'b0, 1, 0, 5};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 10, 8'h04, 1'b1, 1'b0, 1, 0, 5};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 10, 8'h03, 1'b0, 1'b0, 1, 0, 5};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 10, 8'h02, 1'b0, 1'b0, 1, 0, 5};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 10, 8'h01, 1'b0, 1'b0, 1, 0, 5};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 10, 8'h00, 1'b0, 1'b0, 1, 0, 5};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 10, 8'hFF, 1'b0, 1'b0, 1, 1, 5};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 10, 8'h00, 1'b1, 1'b0, 1, 1, 5};
      vecs[10] = '{1'b1, 1'b0, 1'b0,  2, 8'h00, 1'b1, 1'b0, 0, 0, 0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 10, 8'h00, 1'b1, 1'b0, 0, 0, 0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 10, 8'h00, 1'b1, 1'b1, 0, 0, 0};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 10, 8'h00, 1'b1, 1'b0, 0, 0, 0};

      // Static 11 held through reset, then release: no step, no error
      rst = 1'b0;
      qa = 1'b1;
      qb = 1'b1;
      repeat (5) tick();
      check("reset_count", count, 8'h00);
      check("reset_dir", dir, 1'b1);
      check("reset_err", err, 1'b0);
      rst = 1'b1;
      run(20, st, wr, first);
      check("static11_steps", st, 0);
      check("static11_count", count, 8'h00);
      check("static11_err", err, 1'b0);

      // Restart from 00 with count 00
      rst = 1'b0;
      qa = 1'b0;
      qb = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();

      for (int v = 0; v < 14; v++) begin
         qa = vecs[v].a;
         qb = vecs[v].b;
         clr_err = vecs[v].clr;
         run(vecs[v].hold, st, wr, first);
         check($sformatf("v%0d_count", v), count, vecs[v].cnt);
         check($sformatf("v%0d_dir", v), dir, vecs[v].dir);
         check($sformatf("v%0d_err", v), err, vecs[v].err);
         check($sformatf("v%0d_steps", v), st, vecs[v].steps);
         check($sformatf("v%0d_wraps", v), wr, vecs[v].wraps);
         if (vecs[v].lat != 0) check($sformatf("v%0d_latency", v), first, vecs[v].lat);
      end
      clr_err = 1'b0;

      // Illegal 11->00 with clr_err only on the commit edge: error wins
      qa = 1'b0;
      qb = 1'b0;
      run(4, st, wr, first);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("illegal_clr_err", err, 1'b1);
      check("illegal_clr_count", count, 8'h00);
      run(3, st, wr, first);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_err_clears", err, 1'b0);

      // Load FF, forward step overflows, reverse step underflows
      load = 1'b1;
      data = 8'hFF;
      tick();
      load = 1'b0;
      check("load_ff", count, 8'hFF);
      qb = 1'b1;
      run(10, st, wr, first);
      check("ovf_count", count, 8'h00);
      check("ovf_wraps", wr, 1);
      check("ovf_dir", dir, 1'b1);
      qb = 1'b0;
      run(10, st, wr, first);
      check("unf_count", count, 8'hFF);
      check("unf_wraps", wr, 1);
      check("unf_dir", dir, 1'b0);

      // Load on the commit edge of a forward step: step discarded, dir unchanged
      qb = 1'b1;
      run(4, st, wr, first);
      check("pre_load_steps", st, 0);
      load = 1'b1;
      data = 8'h40;
      tick();
      load = 1'b0;
      check("load_commit_count", count, 8'h40);
      check("load_commit_step", step, 1'b0);
      check("load_commit_dir", dir, 1'b0);
      check("load_commit_err", err, 1'b0);
      run(10, st, wr, first);
      check("post_load_steps", st, 0);
      check("post_load_count", count, 8'h40);

      // Reset during a pending window (01->11) aborts the commit
      qa = 1'b1;
      run(2, st, wr, first);
      rst = 1'b0;
      tick();
      check("midwin_rst_count", count, 8'h00);
      check("midwin_rst_step", step, 1'b0);
      repeat (2) tick();
      rst = 1'b1;
      run(10, st, wr, first);
      check("post_rst_steps", st, 0);
      check("post_rst_count", count, 8'h00);
      check("post_rst_err", err, 1'b0);

      // Illegal 11->00 coinciding with load still sets err
      qa = 1'b0;
      qb = 1'b0;
      run(4, st, wr, first);
      load = 1'b1;
      data = 8'h12;
      tick();
      load = 1'b0;
      check("illegal_load_err", err, 1'b1);
      check("illegal_load_count", count, 8'h12);
      check("illegal_load_step", step, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
